io_interface: RTL and testbench

IO_INTERFACE -- requirements
Module: io_interface

---
 rtl/io_interface_pkg.sv | 14 +
 rtl/io_rx_fifo.sv | 61 ++++++
 rtl/io_interface.sv | 95 +++++++++
 tb/tb_io_interface.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_interface_pkg.sv
// Shared definitions for the I/O interface block: default widths/depths
// and the transmit FSM state encoding.
package io_interface_pkg;

    localparam int IO_W_DEF     = 8;
    localparam int RX_DEPTH_DEF = 4;

    // Transmit side: IDLE means the printer path can take a new character.
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage : io_interface_pkg

// File: rtl/io_rx_fifo.sv
// Keyboard receive FIFO. Head entry is presented combinationally; the
// head reads as zero whenever the FIFO is empty.
//
// Handshake: a push is accepted on a rising edge where push_valid and
// push_ready are both 1; push_ready depends only on registered count, so
// a pop in the same cycle never opens a slot for a simultaneous push.
module io_rx_fifo
    import io_interface_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH_DEF,
    parameter int W     = IO_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    input  logic         pop_req,
    output logic         head_valid,
    output logic [W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign push_ready = (count != CW'(DEPTH));
    assign head_valid = (count != '0);
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop_req & head_valid;
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule : io_rx_fifo

// File: rtl/io_interface.sv
// Basic-computer style I/O interface: keyboard input register backed by a
// small FIFO, printer output register with a two-state transmit FSM,
// interrupt enable flag and interrupt request generation.
//
// Handshakes: kb_* and prn_* both transfer on a rising edge where valid
// and ready are 1 together; valid, once raised, holds with stable data
// until that transfer (or reset).
module io_interface
    import io_interface_pkg::*;
#(
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int IO_W     = IO_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IO_W-1:0] ac_in,
    input  logic            inp_exec,
    input  logic            out_exec,
    input  logic            ion_exec,
    input  logic            iof_exec,
    input  logic            int_ack,
    output logic [IO_W-1:0] inpr,
    output logic            fgi,
    output logic            fgo,
    output logic            ien,
    output logic            irq,
    input  logic            kb_valid,
    input  logic [IO_W-1:0] kb_data,
    output logic            kb_ready,
    output logic            prn_valid,
    output logic [IO_W-1:0] prn_data,
    input  logic            prn_ready,
    output logic            tx_ovr,
    output tx_state_e       tx_state
);

    tx_state_e       state;
    logic [IO_W-1:0] outr;

    io_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .W     (IO_W)
    ) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (kb_valid),
        .push_data  (kb_data),
        .push_ready (kb_ready),
        .pop_req    (inp_exec),
        .head_valid (fgi),
        .head_data  (inpr)
    );

    assign tx_state  = state;
    assign fgo       = (state == TX_IDLE);
    assign prn_valid = (state == TX_SEND);
    assign prn_data  = outr;
    assign irq       = ien & (fgi | fgo);

    // Transmit FSM: OUT loads the character, printer acceptance frees it;
    // an OUT while still sending is dropped and flagged stickily.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= TX_IDLE;
            outr   <= '0;
            tx_ovr <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (out_exec) begin
                        outr  <= ac_in;
                        state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (out_exec) tx_ovr <= 1'b1;
                    if (prn_ready) state <= TX_IDLE;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    // Interrupt enable: any clear source takes priority over ION.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ien <= 1'b0;
        end else if (iof_exec || int_ack) begin
            ien <= 1'b0;
        end else if (ion_exec) begin
            ien <= 1'b1;
        end
    end

endmodule : io_interface

// File: tb/tb_io_interface.sv
// Bench for io_interface: directed vectors, expected characters queued by
// the drivers and consumed by monitors at each handshake.
module tb_io_interface;
    import io_interface_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] ac_in;
    logic         inp_exec, out_exec, ion_exec, iof_exec, int_ack;
    logic [W-1:0] inpr;
    logic         fgi, fgo, ien, irq;
    logic         kb_valid;
    logic [W-1:0] kb_data;
    logic         kb_ready;
    logic         prn_valid;
    logic [W-1:0] prn_data;
    logic         prn_ready;
    logic         tx_ovr;
    tx_state_e    tx_state;

    logic [W-1:0] rx_exp_q[$];
    logic [W-1:0] prn_exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    io_interface #(.RX_DEPTH(4), .IO_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ac_in     (ac_in),
        .inp_exec  (inp_exec),
        .out_exec  (out_exec),
        .ion_exec  (ion_exec),
        .iof_exec  (iof_exec),
        .int_ack   (int_ack),
        .inpr      (inpr),
        .fgi       (fgi),
        .fgo       (fgo),
        .ien       (ien),
        .irq       (irq),
        .kb_valid  (kb_valid),
        .kb_data   (kb_data),
        .kb_ready  (kb_ready),
        .prn_valid (prn_valid),
        .prn_data  (prn_data),
        .prn_ready (prn_ready),
        .tx_ovr    (tx_ovr),
        .tx_state  (tx_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs are changed right after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic kb_push(input logic [W-1:0] d);
        kb_valid = 1'b1;
        kb_data  = d;
        tick();
        kb_valid = 1'b0;
    endtask

    task automatic cpu_inp(input logic [W-1:0] exp_d);
        rx_exp_q.push_back(exp_d);
        inp_exec = 1'b1;
        tick();
        inp_exec = 1'b0;
    endtask

    task automatic cpu_out(input logic [W-1:0] d);
        ac_in    = d;
        out_exec = 1'b1;
        tick();
        out_exec = 1'b0;
    endtask

    // ---------------- monitors ----------------
    // INP with a character pending: the datapath takes inpr this cycle.
    always @(negedge clk) begin
        if (rst_n && inp_exec && fgi) begin
            if (rx_exp_q.size() == 0) begin
                check("rx_unexpected_read", 32'(inpr), 32'hFFFF_FFFF);
            end else begin
                check("rx_inpr", 32'(inpr), 32'(rx_exp_q.pop_front()));
            end
        end
    end

    // Printer handshake: every accepted character must match the queue head.
    always @(negedge clk) begin
        if (rst_n && prn_valid && prn_ready) begin
            if (prn_exp_q.size() == 0) begin
                check("prn_unexpected_xfer", 32'(prn_data), 32'hFFFF_FFFF);
            end else begin
                check("prn_data_xfer", 32'(prn_data), 32'(prn_exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; ac_in = '0; inp_exec = 0; out_exec = 0; ion_exec = 0;
        iof_exec = 0; int_ack = 0; kb_valid = 0; kb_data = '0; prn_ready = 0;

        // Reset state
        tick(); tick();
        mid();
        check("rst_fgi", 32'(fgi), 0);
        check("rst_inpr", 32'(inpr), 0);
        check("rst_kb_ready", 32'(kb_ready), 1);
        check("rst_fgo", 32'(fgo), 1);
        check("rst_prn_valid", 32'(prn_valid), 0);
        check("rst_prn_data", 32'(prn_data), 0);
        check("rst_ien", 32'(ien), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_tx_ovr", 32'(tx_ovr), 0);
        tick();
        rst_n = 1'b1;

        // Single keyboard byte, interrupt enabled
        ion_exec = 1'b1; tick(); ion_exec = 1'b0;
        mid();
        check("ion_sets_ien", 32'(ien), 1);
        tick();
        kb_push(8'h41);
        mid();
        check("one_fgi", 32'(fgi), 1);
        check("one_inpr", 32'(inpr), 32'h41);
        check("one_irq", 32'(irq), 1);
        tick();
        cpu_inp(8'h41);
        mid();
        check("one_drained_fgi", 32'(fgi), 0);
        check("one_drained_inpr", 32'(inpr), 0);

        // Fill to full, overflow attempt, push/pop interplay, drain
        tick();
        for (int i = 1; i <= 4; i++) kb_push(8'(i));
        mid();
        check("full_kb_ready", 32'(kb_ready), 0);
        check("full_inpr", 32'(inpr), 32'h01);
        tick();
        kb_push(8'h05);
        // Pop while full with a push offered: push must be refused.
        rx_exp_q.push_back(8'h01);
        inp_exec = 1'b1; kb_valid = 1'b1; kb_data = 8'h06;
        tick();
        inp_exec = 1'b0; kb_valid = 1'b0;
        mid();
        check("after_full_pop_kb_ready", 32'(kb_ready), 1);
        check("after_full_pop_inpr", 32'(inpr), 32'h02);
        tick();
        // Simultaneous push and pop at count 3: count stays 3.
        rx_exp_q.push_back(8'h02);
        inp_exec = 1'b1; kb_valid = 1'b1; kb_data = 8'h07;
        tick();
        inp_exec = 1'b0; kb_valid = 1'b0;
        mid();
        check("pushpop_kb_ready", 32'(kb_ready), 1);
        check("pushpop_inpr", 32'(inpr), 32'h03);
        tick();
        cpu_inp(8'h03);
        cpu_inp(8'h04);
        cpu_inp(8'h07);
        mid();
        check("drained_fgi", 32'(fgi), 0);
        check("drained_inpr", 32'(inpr), 0);
        tick();
        // INP with nothing pending is ignored (no underflow).
        inp_exec = 1'b1; tick(); inp_exec = 1'b0;
        mid();
        check("empty_inp_fgi", 32'(fgi), 0);
        check("empty_inp_kb_ready", 32'(kb_ready), 1);
        tick();

        // Printer transfer with back-pressure and an overrun attempt
        prn_exp_q.push_back(8'h5A);
        cpu_out(8'h5A);
        mid();
        check("send_fgo", 32'(fgo), 0);
        check("send_prn_valid", 32'(prn_valid), 1);
        check("send_prn_data", 32'(prn_data), 32'h5A);
        check("send_state", 32'(tx_state), 32'(TX_SEND));
        check("send_irq_off", 32'(irq), 0);
        tick();
        cpu_out(8'h33);
        for (int c = 0; c < 3; c++) begin
            mid();
            check("hold_prn_valid", 32'(prn_valid), 1);
            check("hold_prn_data", 32'(prn_data), 32'h5A);
            tick();
        end
        check("ovr_set", 32'(tx_ovr), 1);
        prn_ready = 1'b1; tick(); prn_ready = 1'b0;
        mid();
        check("done_fgo", 32'(fgo), 1);
        check("done_prn_valid", 32'(prn_valid), 0);
        check("done_prn_data", 32'(prn_data), 32'h5A);
        check("ovr_sticky", 32'(tx_ovr), 1);
        check("done_irq", 32'(irq), 1);
        tick();

        // Clear beats set on IEN
        ion_exec = 1'b1; int_ack = 1'b1; tick(); ion_exec = 1'b0; int_ack = 1'b0;
        mid();
        check("ack_beats_ion", 32'(ien), 0);
        tick();
        ion_exec = 1'b1; tick(); ion_exec = 1'b0;
        iof_exec = 1'b1; tick(); iof_exec = 1'b0;
        mid();
        check("iof_clears_ien", 32'(ien), 0);
        tick();

        // Asynchronous reset in the middle of a send with two bytes queued
        kb_push(8'hA1);
        kb_push(8'hA2);
        cpu_out(8'h77);
        mid();
        check("pre_rst_prn_valid", 32'(prn_valid), 1);
        check("pre_rst_fgi", 32'(fgi), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_fgo", 32'(fgo), 1);
        check("async_rst_fgi", 32'(fgi), 0);
        check("async_rst_prn_valid", 32'(prn_valid), 0);
        check("async_rst_inpr", 32'(inpr), 0);
        check("async_rst_tx_ovr", 32'(tx_ovr), 0);
        check("async_rst_prn_data", 32'(prn_data), 0);
        tick();
        rst_n = 1'b1;
        prn_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            check("post_rst_no_prn_valid", 32'(prn_valid), 0);
            tick();
        end
        prn_ready = 1'b0;

        tick();
        check("rx_queue_empty", 32'(rx_exp_q.size()), 0);
        check("prn_queue_empty", 32'(prn_exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_io_interface
